// File: rtl/adpll_cfg_sequencer.sv
// rtl/adpll_cfg_sequencer.sv - ADPLL parameter-programming port master sequencer
module adpll_cfg_sequencer #(
    parameter int NPARAM        = 6,
    parameter int PW            = 5,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [NPARAM*PW-1:0] cfg_bus_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 pll_rst_o,
    output logic                 program_o,
    output logic [2:0]           param_sel_o,
    output logic [PW-1:0]        pgm_value_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RST_ASSERT,
        S_WRITE,
        S_SETTLE,
        S_RELEASE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_IDX    = 3'(NPARAM - 1);

    state_t                state_q;
    logic [NPARAM*PW-1:0]  cfg_q;
    logic [2:0]            idx_q;
    logic [3:0]            cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic                  pll_rst_q;
    logic                  program_q;
    logic [2:0]            param_sel_q;
    logic [PW-1:0]         pgm_value_q;

    logic [2:0]            nidx_d;
    logic [PW-1:0]         first_val_d;
    logic [PW-1:0]         next_val_d;
    logic                  reject_bus_d;
    logic                  reject_cfg_d;

    // Ndiv (field 0) and kdco (last field) of zero would leave the loop unusable.
    always_comb begin
        reject_bus_d = (cfg_bus_i[PW-1:0] == '0)
                    || (cfg_bus_i[(NPARAM-1)*PW +: PW] == '0);
        reject_cfg_d = (cfg_q[PW-1:0] == '0)
                    || (cfg_q[(NPARAM-1)*PW +: PW] == '0);
    end

    always_comb begin
        nidx_d      = idx_q + 3'd1;
        first_val_d = cfg_q[PW-1:0];
        next_val_d  = '0;
        for (int k = 0; k < NPARAM; k++) begin
            if (nidx_d == 3'(k)) begin
                next_val_d = cfg_q[k*PW +: PW];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cfg_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pll_rst_q   <= 1'b1;
            program_q   <= 1'b0;
            param_sel_q <= '0;
            pgm_value_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        cfg_q   <= cfg_bus_i;
                        busy_q  <= 1'b1;
                        // err is raised on the capture edge so it is visible during CHECK.
                        err_q   <= reject_bus_d;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (reject_cfg_d) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        pll_rst_q <= 1'b1;
                        program_q <= 1'b0;
                        state_q   <= S_RST_ASSERT;
                    end
                end
                S_RST_ASSERT: begin
                    program_q   <= 1'b1;
                    idx_q       <= '0;
                    param_sel_q <= '0;
                    pgm_value_q <= first_val_d;
                    state_q     <= S_WRITE;
                end
                S_WRITE: begin
                    if (idx_q == LAST_IDX) begin
                        program_q   <= 1'b0;
                        param_sel_q <= '0;
                        pgm_value_q <= '0;
                        cnt_q       <= SETTLE_LAST;
                        state_q     <= S_SETTLE;
                    end else begin
                        idx_q       <= nidx_d;
                        param_sel_q <= nidx_d;
                        pgm_value_q <= next_val_d;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        pll_rst_q <= 1'b0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RELEASE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign pll_rst_o   = pll_rst_q;
    assign program_o   = program_q;
    assign param_sel_o = param_sel_q;
    assign pgm_value_o = pgm_value_q;

endmodule

// File: tb/tb_adpll_cfg_sequencer.sv
// tb/tb_adpll_cfg_sequencer.sv - scoreboard bench for adpll_cfg_sequencer
module tb_adpll_cfg_sequencer;

    localparam int S = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [29:0] cfg_bus;
    logic        busy;
    logic        done;
    logic        err;
    logic        pll_rst;
    logic        program_s;
    logic [2:0]  param_sel;
    logic [4:0]  pgm_value;

    adpll_cfg_sequencer #(.NPARAM(6), .PW(5), .SETTLE_CYCLES(S)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .cfg_bus_i   (cfg_bus),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .pll_rst_o   (pll_rst),
        .program_o   (program_s),
        .param_sel_o (param_sel),
        .pgm_value_o (pgm_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = write strobe, 1 = done pulse, 2 = err pulse
    typedef struct {
        int kind;
        int at;
        int sel;
        int val;
        int pll;
    } ev_t;

    ev_t exp_q[$];
    int  tests;
    int  fails;
    int  edge_cnt;
    int  next_ok;
    int  pll_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference model: decides acceptance from the start edge and the rules, then schedules outputs.
    task automatic model(input int e, input logic [29:0] cfg);
        ev_t ev;
        logic [4:0] f [6];
        if (e < next_ok) return;
        for (int k = 0; k < 6; k++) f[k] = cfg[k*5 +: 5];
        if (f[0] == 0 || f[5] == 0) begin
            ev = '{kind: 2, at: e, sel: 0, val: 0, pll: pll_model};
            exp_q.push_back(ev);
            next_ok = e + 2;
        end else begin
            for (int k = 0; k < 6; k++) begin
                ev = '{kind: 0, at: e + 2 + k, sel: k, val: int'(f[k]), pll: 1};
                exp_q.push_back(ev);
            end
            ev = '{kind: 1, at: e + 8 + S, sel: 0, val: 0, pll: 0};
            exp_q.push_back(ev);
            next_ok   = e + 10 + S;
            pll_model = 0;
        end
    endtask

    task automatic drive(input logic s, input logic [29:0] cfg);
        @(negedge clk);
        start   = s;
        cfg_bus = cfg;
        if (s) model(edge_cnt + 1, cfg);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 30'($urandom));
    endtask

    function automatic logic [29:0] mk(input int kd, input int th, input int of,
                                       input int be, input int al, input int nd);
        return {5'(kd), 5'(th), 5'(of), 5'(be), 5'(al), 5'(nd)};
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or pulse.
    initial begin
        ev_t e;
        int  kind;
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            if (rst_n) begin
                if (program_s) begin
                    check("pll_rst_while_program", pll_rst, 1);
                    check("param_sel_range", param_sel < 3'd6, 1);
                end
                if (program_s || done || err) begin
                    check("single_event", 32'(program_s) + 32'(done) + 32'(err), 1);
                    kind = program_s ? 0 : (done ? 1 : 2);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_event: got kind %0d expected none (edge %0d)", kind, edge_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", kind, e.kind);
                        check("event_edge", edge_cnt, e.at);
                        if (kind == 0) begin
                            check("write_sel", param_sel, e.sel);
                            check("write_val", pgm_value, e.val);
                            check("write_busy", busy, 1);
                        end else if (kind == 1) begin
                            check("done_pll_rst", pll_rst, 0);
                            check("done_busy", busy, 0);
                        end else begin
                            check("err_pll_rst", pll_rst, e.pll);
                        end
                    end
                end
                while (exp_q.size() > 0 && exp_q[0].at < edge_cnt) begin
                    tests++;
                    fails++;
                    $display("FAIL missing_event: got nothing expected kind %0d at edge %0d", exp_q[0].kind, exp_q[0].at);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        tests     = 0;
        fails     = 0;
        edge_cnt  = 0;
        next_ok   = 0;
        pll_model = 1;
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_bus   = '0;
        repeat (3) @(negedge clk);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_program", program_s, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_param_sel", param_sel, 0);
        check("rst_pgm_value", pgm_value, 0);
        rst_n   = 1'b1;
        next_ok = edge_cnt + 1;

        // Reject on Ndiv straight after reset: loop stays held.
        drive(1'b1, mk(1, 10, 8, 4, 4, 0));
        idle(4);
        // Nominal sequence.
        drive(1'b1, mk(1, 10, 8, 4, 4, 1));
        idle(16);
        // Reject on kdco after a success: pll_rst stays low.
        drive(1'b1, mk(0, 10, 8, 4, 4, 3));
        idle(4);
        // Busy collision: second start at T+5 is ignored.
        drive(1'b1, mk(7, 9, 11, 13, 15, 17));
        idle(4);
        drive(1'b1, mk(31, 31, 31, 31, 31, 31));
        idle(16);
        // Start in RELEASE ignored, start in the following IDLE accepted.
        drive(1'b1, mk(2, 3, 4, 5, 6, 7));
        idle(12);
        drive(1'b1, mk(9, 9, 9, 9, 9, 9));
        drive(1'b1, mk(21, 22, 23, 24, 25, 26));
        idle(16);

        // Abort mid-write at T+6.
        drive(1'b1, mk(5, 6, 7, 8, 9, 10));
        idle(6);
        @(posedge clk);
        #2;
        check("abort_program_before", program_s, 1);
        rst_n = 1'b0;
        #1;
        check("abort_program", program_s, 0);
        check("abort_pll_rst", pll_rst, 1);
        check("abort_busy", busy, 0);
        exp_q.delete();
        pll_model = 1;
        @(negedge clk);
        rst_n   = 1'b1;
        next_ok = edge_cnt + 1;
        drive(1'b1, mk(1, 10, 8, 4, 4, 1));
        idle(16);
        // Reprogram with Ndiv = 2.
        drive(1'b1, mk(1, 10, 8, 4, 4, 2));
        idle(16);

        // Randomized traffic with occasional zero Ndiv/kdco.
        for (int n = 0; n < 400; n++) begin
            logic [29:0] c;
            c = 30'($urandom);
            if ($urandom_range(0, 5) == 0) c[4:0]   = '0;
            if ($urandom_range(0, 5) == 0) c[29:25] = '0;
            drive($urandom_range(0, 3) == 0, c);
        end
        idle(20);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
